// File: rtl/pmem_arbiter.sv
// Merges I-cache and D-cache line requests onto one physical-memory bus.
// The granted requester owns the bus until pmem_resp; priority alternates on each completion.
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  typedef enum logic {
    PRIO_I = 1'b0,
    PRIO_D = 1'b1
  } prio_t;

  state_t state, state_nxt;
  prio_t  prio, prio_nxt;
  logic   d_req;
  logic   grant_i;
  logic   grant_d;
  logic   done;

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    done      = 1'b0;
    d_req     = d_pmem_read | d_pmem_write;
    case (state)
      IDLE: begin
        // pmem_resp arriving here (e.g. from an abandoned transfer) is deliberately ignored
        if (i_pmem_read && (!d_req || prio == PRIO_I)) begin
          grant_i   = 1'b1;
          state_nxt = GNT_I;
        end else if (d_req) begin
          grant_d   = 1'b1;
          state_nxt = GNT_D;
        end
      end
      GNT_I: begin
        if (pmem_resp) begin
          done      = 1'b1;
          state_nxt = IDLE;
          prio_nxt  = PRIO_D;
        end
      end
      GNT_D: begin
        if (pmem_resp) begin
          done      = 1'b1;
          state_nxt = IDLE;
          prio_nxt  = PRIO_I;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only the response is steered; read data simply mirrors the bus to both caches.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = !reset && (state == GNT_I) && pmem_resp;
  assign d_pmem_resp  = !reset && (state == GNT_D) && pmem_resp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      prio         <= PRIO_I;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      if (grant_i) begin
        pmem_address <= i_pmem_address;
        pmem_read    <= 1'b1;
        pmem_write   <= 1'b0;
      end else if (grant_d) begin
        // A simultaneous read+write from the D side is treated as a write
        pmem_address <= d_pmem_address;
        pmem_wdata   <= d_pmem_wdata;
        pmem_write   <= d_pmem_write;
        pmem_read    <= !d_pmem_write;
      end else if (done) begin
        pmem_read    <= 1'b0;
        pmem_write   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level model of the arbitration rules.
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  pmem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the bus, whose turn it is, and what was latched at grant.
  int           m_owner = 0;  // 0 none, 1 I-cache, 2 D-cache
  bit           m_prio  = 1'b0; // 0 favours I, 1 favours D
  logic         m_rd = 1'b0;
  logic         m_wr = 1'b0;
  logic [15:0]  m_addr = '0;
  logic [127:0] m_wdata = '0;

  bit           checking = 1'b0;
  bit           prev_strobe = 1'b0;
  bit           i_got = 1'b0;
  bit           d_got = 1'b0;
  logic [15:0]  grant_log[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already driven; checks, advances the model, returns at next negedge.
  task automatic step();
    bit dreq;
    #1;
    if (checking) begin
      chk1("pmem_read", pmem_read, m_rd);
      chk1("pmem_write", pmem_write, m_wr);
      if (m_rd || m_wr) chk("pmem_address", 128'(pmem_address), 128'(m_addr));
      if (m_wr) chk("pmem_wdata", pmem_wdata, m_wdata);
      chk1("i_resp", i_pmem_resp, !reset && m_owner == 1 && pmem_resp);
      chk1("d_resp", d_pmem_resp, !reset && m_owner == 2 && pmem_resp);
      chk("i_rdata", i_pmem_rdata, pmem_rdata);
      chk("d_rdata", d_pmem_rdata, pmem_rdata);
      chk1("excl_strobe", pmem_read && pmem_write, 1'b0);
      chk1("excl_resp", i_pmem_resp && d_pmem_resp, 1'b0);
    end
    i_got = i_pmem_resp;
    d_got = d_pmem_resp;
    if ((pmem_read || pmem_write) && !prev_strobe) grant_log.push_back(pmem_address);
    prev_strobe = pmem_read || pmem_write;
    dreq = d_pmem_read || d_pmem_write;
    if (reset) begin
      m_owner = 0; m_prio = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    end else if (m_owner == 0) begin
      if (i_pmem_read && (!dreq || m_prio == 1'b0)) begin
        m_owner = 1; m_rd = 1'b1; m_wr = 1'b0; m_addr = i_pmem_address;
      end else if (dreq) begin
        m_owner = 2; m_wr = d_pmem_write; m_rd = !d_pmem_write;
        m_addr = d_pmem_address; m_wdata = d_pmem_wdata;
      end
    end else if (pmem_resp) begin
      m_prio = (m_owner == 1);
      m_owner = 0; m_rd = 1'b0; m_wr = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; pmem_resp = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checking = 1'b1;
  endtask

  // Waits (bounded) for a strobe, holds it waitc cycles, then pulses pmem_resp.
  task automatic serve(input string tag, input int waitc);
    int n = 0;
    while (!(pmem_read || pmem_write) && n < 6) begin
      step();
      n++;
    end
    chk1({tag, "_strobe"}, pmem_read || pmem_write, 1'b1);
    repeat (waitc) step();
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
  endtask

  initial begin
    int i_req_cnt = 0, i_resp_cnt = 0, d_req_cnt = 0, d_resp_cnt = 0;
    int i_age = 0, d_age = 0, i_age_max = 0, d_age_max = 0;
    bit pm_busy = 1'b0;
    int pm_wait = 0;
    bit wsel;

    reset = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    @(negedge clk);

    // Test 1: lone I read
    do_reset();
    chk("t1_rst_addr", 128'(pmem_address), 128'h0);
    chk("t1_rst_wdata", pmem_wdata, 128'h0);
    chk1("t1_rst_rd", pmem_read, 1'b0);
    chk1("t1_rst_wr", pmem_write, 1'b0);
    i_pmem_read = 1'b1; i_pmem_address = 16'h1230;
    step();
    chk1("t1_rd", pmem_read, 1'b1);
    chk1("t1_wr", pmem_write, 1'b0);
    chk("t1_addr", 128'(pmem_address), 128'h1230);
    step();
    step();
    pmem_rdata = {4{32'hC0DE_0001}};
    pmem_resp = 1'b1;
    #1;
    chk1("t1_i_resp", i_pmem_resp, 1'b1);
    chk1("t1_d_resp", d_pmem_resp, 1'b0);
    chk("t1_i_rdata", i_pmem_rdata, {4{32'hC0DE_0001}});
    step();
    pmem_resp = 1'b0;
    i_pmem_read = 1'b0;
    chk1("t1_rd_clear", pmem_read, 1'b0);
    chk1("t1_i_resp_once", i_pmem_resp, 1'b0);

    // Test 2: D writeback, wdata latched at grant
    d_pmem_write = 1'b1; d_pmem_address = 16'h4440; d_pmem_wdata = {16{8'hAA}};
    step();
    chk1("t2_wr", pmem_write, 1'b1);
    chk1("t2_rd", pmem_read, 1'b0);
    chk("t2_addr", 128'(pmem_address), 128'h4440);
    chk("t2_wdata", pmem_wdata, {16{8'hAA}});
    d_pmem_wdata = {16{8'h55}};
    step();
    chk("t2_wdata_hold", pmem_wdata, {16{8'hAA}});
    pmem_resp = 1'b1;
    #1;
    chk1("t2_d_resp", d_pmem_resp, 1'b1);
    chk1("t2_i_resp", i_pmem_resp, 1'b0);
    step();
    pmem_resp = 1'b0;
    d_pmem_write = 1'b0;
    chk1("t2_wr_clear", pmem_write, 1'b0);

    // Test 3: simultaneous requests after reset, both held
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 16'h1000;
    d_pmem_read = 1'b1; d_pmem_address = 16'h2000;
    step();
    chk1("t3_first_rd", pmem_read, 1'b1);
    chk("t3_first_addr", 128'(pmem_address), 128'h1000);
    step();
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    chk1("t3_idle_gap", pmem_read || pmem_write, 1'b0);
    step();
    chk1("t3_second_rd", pmem_read, 1'b1);
    chk("t3_second_addr", 128'(pmem_address), 128'h2000);
    serve("t3d", 0);
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    step();

    // Test 4: uncontested D completion, then six contested transfers alternate starting with I
    do_reset();
    d_pmem_read = 1'b1; d_pmem_address = 16'h2000;
    serve("t4u", 1);
    i_pmem_read = 1'b1; i_pmem_address = 16'h1000;
    grant_log.delete();
    for (int k = 0; k < 6; k++) serve("t4", 1);
    chk("t4_ngrants", 128'(grant_log.size()), 128'd6);
    for (int k = 0; k < 6; k++)
      if (k < grant_log.size())
        chk($sformatf("t4_grant%0d", k), 128'(grant_log[k]), (k % 2 == 0) ? 128'h1000 : 128'h2000);
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    step();
    step();

    // Test 5: reset during GNT_D, then a stray pmem_resp in IDLE
    do_reset();
    d_pmem_write = 1'b1; d_pmem_address = 16'h3000; d_pmem_wdata = {4{$urandom}};
    step();
    chk1("t5_wr", pmem_write, 1'b1);
    reset = 1'b1;
    d_pmem_write = 1'b0;
    step();
    reset = 1'b0;
    chk1("t5_wr_cleared", pmem_write, 1'b0);
    chk1("t5_rd_cleared", pmem_read, 1'b0);
    chk("t5_addr_cleared", 128'(pmem_address), 128'h0);
    pmem_resp = 1'b1;
    #1;
    chk1("t5_no_d_resp", d_pmem_resp, 1'b0);
    chk1("t5_no_i_resp", i_pmem_resp, 1'b0);
    step();
    pmem_resp = 1'b0;
    step();
    chk1("t5_idle_rd", pmem_read, 1'b0);
    chk1("t5_idle_wr", pmem_write, 1'b0);
    i_pmem_read = 1'b1; i_pmem_address = 16'h5550;
    step();
    chk1("t5_regrant", pmem_read, 1'b1);
    chk("t5_regrant_addr", 128'(pmem_address), 128'h5550);
    serve("t5", 0);
    i_pmem_read = 1'b0;
    step();

    // Test 6: random traffic
    for (int c = 0; c < 3000; c++) begin
      if (i_got) begin
        i_pmem_read = 1'b0; i_resp_cnt++;
      end else if (!i_pmem_read && c < 2850 && $urandom_range(2) == 0) begin
        i_pmem_read = 1'b1; i_pmem_address = 16'($urandom) & 16'hFFF0;
        i_req_cnt++; i_age = 0;
      end
      if (d_got) begin
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_resp_cnt++;
      end else if (!(d_pmem_read || d_pmem_write) && c < 2850 && $urandom_range(2) == 0) begin
        wsel = 1'($urandom_range(1));
        d_pmem_write = wsel; d_pmem_read = !wsel;
        d_pmem_address = 16'($urandom) & 16'hFFF0;
        d_req_cnt++; d_age = 0;
      end
      if (d_pmem_read || d_pmem_write) d_pmem_wdata = {4{$urandom}};
      if (i_pmem_read) begin i_age++; if (i_age > i_age_max) i_age_max = i_age; end
      if (d_pmem_read || d_pmem_write) begin d_age++; if (d_age > d_age_max) d_age_max = d_age; end
      if (pmem_read || pmem_write) begin
        if (!pm_busy) begin pm_busy = 1'b1; pm_wait = $urandom_range(3); end
        if (pm_wait == 0) begin pmem_resp = 1'b1; pm_busy = 1'b0; end
        else begin pmem_resp = 1'b0; pm_wait--; end
      end else begin
        pmem_resp = ($urandom_range(19) == 0);
      end
      pmem_rdata = {4{$urandom}};
      step();
    end
    chk("t6_i_answered", 128'(i_resp_cnt), 128'(i_req_cnt));
    chk("t6_d_answered", 128'(d_resp_cnt), 128'(d_req_cnt));
    chk1("t6_i_no_starve", i_age_max <= 30, 1'b1);
    chk1("t6_d_no_starve", d_age_max <= 30, 1'b1);
    chk1("t6_drained", i_pmem_read || d_pmem_read || d_pmem_write, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
